fb_write_arbiter: RTL and testbench
===================================

Name: fb_write_arbiter

Overview:
- Upstream front end of the on-chip frame buffer.
- Accepts pixel writes (x, y, color) from the ray-tracer core over a valid/ready handshake and buffers them in a small FIFO.
- Time-multiplexes the single-port OCM between VGA scan reads and queued writes on a fixed 4-slot schedule, and registers the scanned pixel for the VGA colour path.
- Replaces the ad-hoc slot/test-pattern logic in the top level.

Parameters:
- H_RES, 640, visible columns; x must be < H_RES.
- V_RES, 480, visible rows; y must be < V_RES.
- ADDR_W, 19, OCM address width.
- DATA_W, 4, pixel colour width.
- FIFO_DEPTH, 8, write FIFO entries (power of two).

Ports:
- CLK  in  1  system clock (MAIN_CLK from PLL).
- RESET_N  in  1  asynchronous, active-low reset.
- PIX_X  in  10  write column.
- PIX_Y  in  10  write row.
- PIX_COLOR  in  DATA_W  write colour.
- PIX_VALID  in  1  write request.
- PIX_READY  out  1  FIFO can accept.
- DRAW_X  in  10  VGA scan column.
- DRAW_Y  in  10  VGA scan row.
- VGA_PIXEL  out  DATA_W  registered scan colour.
- OCM_ADDR  out  ADDR_W  OCM address.
- OCM_DATAIN  out  DATA_W  OCM write data.
- OCM_WE  out  1  OCM write enable.
- OCM_DATAOUT  in  DATA_W  OCM read data; valid one cycle after the address is driven.
- FIFO_COUNT  out  4  current occupancy, 0..FIFO_DEPTH.
- OOB_COUNT  out  8  dropped out-of-range writes, saturating.

Behaviour:
- Reset (RESET_N low, asynchronous): SLOT=0, FIFO empty, FIFO_COUNT=0, VGA_PIXEL=0, OOB_COUNT=0, PIX_READY=0, OCM_WE=0.
  - PIX_READY goes to 1 on the first CLK edge after release via a registered enable flop.
- SLOT is a 2-bit free-running counter, increments every cycle and wraps 3→0.
- SLOT 0 (scan read):
  - OCM_ADDR = DRAW_X + H_RES*DRAW_Y; OCM_WE=0; OCM_DATAIN=0.
  - If DRAW_X>=H_RES or DRAW_Y>=V_RES, OCM_ADDR=0.
- SLOT 1 (sample + write):
  - VGA_PIXEL <= OCM_DATAOUT at the edge ending slot 1.
  - If the FIFO is non-empty: OCM_ADDR/OCM_DATAIN = head entry, OCM_WE=1, head popped at the edge ending slot 1.
- SLOT 3 (write): same write/pop rule as slot 1, without the VGA_PIXEL update.
- SLOT 2: idle; OCM_ADDR=0, OCM_WE=0, OCM_DATAIN=0.
- OCM outputs are combinational from SLOT and the FIFO head only. They never depend on PIX_* in the same cycle, so there is no input-to-OCM path.
- Push rules:
  - Push occurs on PIX_VALID && PIX_READY.
  - Address x + H_RES*y is computed at push time and stored ADDR_W wide with the colour; stored data is not truncated.
  - PIX_READY = enable && (FIFO_COUNT != FIFO_DEPTH).
  - When full, PIX_READY=0 even if a pop happens that cycle; there is no full-bypass.
- Out-of-range push (PIX_X>=H_RES or PIX_Y>=V_RES): handshake completes, nothing is stored, OOB_COUNT increments and saturates at 255.
- Simultaneous push and pop: FIFO_COUNT is unchanged and both pointers advance.
- Upstream may hold PIX_VALID high with changing data only after a completed handshake. Data is sampled only on the handshake edge.
- Write throughput is 2 per 4 cycles. Write-to-visible latency is at most 4 cycles after the entry reaches the FIFO head.
- FIFO order is strict FIFO. The same address written twice lands in arrival order.
- Reset mid-burst discards all queued entries; no OCM_WE after reset until a new push.

Test Plan:
- Reset check: hold RESET_N low 3 cycles → all outputs 0, PIX_READY=0; release → PIX_READY=1 next edge, SLOT sequence 0,1,2,3,0 observed via OCM_WE/addr pattern.
- Single write/readback: push (0,0,color 5), then DRAW=(0,0) → OCM_WE=1 with OCM_ADDR=0, OCM_DATAIN=5 in the next slot 1 or 3; a following scan read gives VGA_PIXEL=5 after slot 1.
- Corner address: push (639,479,color 9) → write to OCM_ADDR=307199; push (640,0) and (0,480) → no OCM_WE for either, OOB_COUNT=2, handshakes completed.
- Backpressure: PIX_VALID held high for 24 pixels (x=0..23, y=1, colour=x[3:0]) → FIFO_COUNT reaches 8, PIX_READY drops, no entry lost; writes emitted in order at addresses 640..663 with matching data, only in slots 1/3.
- Reset mid-burst: queue 6 entries, assert RESET_N low mid-slot-2 → FIFO_COUNT=0 immediately, no further OCM_WE; the next push after release is written first.
- OOB saturation: 300 out-of-range pushes → OOB_COUNT holds 255, FIFO_COUNT stays 0.

Source files
------------

// File: rtl/fb_write_arbiter_if.sv
// Pixel-write, VGA-scan and OCM bus bundle for the frame-buffer write arbiter.
// The slave side belongs to the arbiter; the master side drives writes and scan coordinates.
interface fb_write_arbiter_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 4
);
    logic [9:0]        pix_x;
    logic [9:0]        pix_y;
    logic [DATA_W-1:0] pix_color;
    logic              pix_valid;
    logic              pix_ready;
    logic [9:0]        draw_x;
    logic [9:0]        draw_y;
    logic [DATA_W-1:0] vga_pixel;
    logic [ADDR_W-1:0] ocm_addr;
    logic [DATA_W-1:0] ocm_datain;
    logic              ocm_we;
    logic [DATA_W-1:0] ocm_dataout;
    logic [3:0]        fifo_count;
    logic [7:0]        oob_count;

    modport slave (
        input  pix_x, pix_y, pix_color, pix_valid, draw_x, draw_y, ocm_dataout,
        output pix_ready, vga_pixel, ocm_addr, ocm_datain, ocm_we, fifo_count, oob_count
    );

    modport master (
        output pix_x, pix_y, pix_color, pix_valid, draw_x, draw_y, ocm_dataout,
        input  pix_ready, vga_pixel, ocm_addr, ocm_datain, ocm_we, fifo_count, oob_count
    );
endinterface

// File: rtl/fb_write_arbiter.sv
// Frame-buffer front end: queues pixel writes in a small FIFO and shares the
// single-port OCM between VGA scan reads and queued writes on a 4-slot schedule.
//
//   state        | meaning
//   SLOT_SCAN    | OCM read at the current VGA scan address
//   SLOT_SAMPLE  | capture scan data into vga_pixel; write FIFO head if any
//   SLOT_IDLE    | OCM quiet
//   SLOT_WRITE   | write FIFO head if any
module fb_write_arbiter #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    fb_write_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        SLOT_SCAN   = 2'd0,
        SLOT_SAMPLE = 2'd1,
        SLOT_IDLE   = 2'd2,
        SLOT_WRITE  = 2'd3
    } slot_e;

    slot_e slot_q, slot_d;

    logic                     en_q;
    logic [ADDR_W+DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [DATA_W-1:0]        vga_q;
    logic [7:0]               oob_q;

    logic              fifo_full, fifo_empty;
    logic              push_hs, in_range, push, pop;
    logic [ADDR_W-1:0] push_addr, scan_addr;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [ADDR_W-1:0] ocm_addr;
    logic [DATA_W-1:0] ocm_datain;
    logic              ocm_we;

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push_hs    = bus.pix_valid && bus.pix_ready;
    assign in_range   = (bus.pix_x < 10'(H_RES)) && (bus.pix_y < 10'(V_RES));
    assign push       = push_hs && in_range;
    assign pop        = ocm_we;

    assign push_addr = ADDR_W'(bus.pix_x) + ADDR_W'(H_RES) * ADDR_W'(bus.pix_y);
    assign scan_addr = ((bus.draw_x < 10'(H_RES)) && (bus.draw_y < 10'(V_RES)))
                       ? ADDR_W'(bus.draw_x) + ADDR_W'(H_RES) * ADDR_W'(bus.draw_y)
                       : '0;
    assign {head_addr, head_data} = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) slot_q <= SLOT_SCAN;
        else          slot_q <= slot_d;
    end

    always_comb begin
        slot_d = SLOT_SCAN;
        unique case (slot_q)
            SLOT_SCAN:   slot_d = SLOT_SAMPLE;
            SLOT_SAMPLE: slot_d = SLOT_IDLE;
            SLOT_IDLE:   slot_d = SLOT_WRITE;
            SLOT_WRITE:  slot_d = SLOT_SCAN;
            default:     slot_d = SLOT_SCAN;
        endcase
    end

    // OCM drive depends only on the slot and stored state, never on pix_* this cycle.
    always_comb begin
        ocm_addr   = '0;
        ocm_datain = '0;
        ocm_we     = 1'b0;
        unique case (slot_q)
            SLOT_SCAN: ocm_addr = scan_addr;
            SLOT_SAMPLE, SLOT_WRITE: begin
                if (!fifo_empty) begin
                    ocm_addr   = head_addr;
                    ocm_datain = head_data;
                    ocm_we     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            en_q     <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vga_q    <= '0;
            oob_q    <= '0;
        end else begin
            en_q    <= 1'b1;
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (slot_q == SLOT_SAMPLE) vga_q <= bus.ocm_dataout;
            if (push_hs && !in_range && (oob_q != 8'hFF)) oob_q <= oob_q + 8'd1;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= {push_addr, bus.pix_color};
    end

    assign bus.pix_ready  = en_q && !fifo_full;
    assign bus.vga_pixel  = vga_q;
    assign bus.ocm_addr   = ocm_addr;
    assign bus.ocm_datain = ocm_datain;
    assign bus.ocm_we     = ocm_we;
    assign bus.fifo_count = 4'(count_q);
    assign bus.oob_count  = oob_q;
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scoreboard bench for fb_write_arbiter: expected OCM writes are queued at each
// handshake and compared as the arbiter emits them; a behavioural OCM feeds scan reads.
module tb_fb_write_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fb_write_arbiter_if bus ();

    fb_write_arbiter dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [18:0] addr;
        logic [3:0]  data;
    } wr_t;

    int   checks = 0;
    int   failures = 0;
    wr_t  sb[$];
    wr_t  exp_wr;
    int   exp_scan;
    int   oob_model = 0;
    int   max_cnt = 0;
    logic [1:0] tb_slot = 2'd0;
    logic       tb_en = 1'b0;
    logic [3:0] ocm_mem [0:307199];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tb_slot <= 2'd0;
            tb_en   <= 1'b0;
        end else begin
            tb_slot <= tb_slot + 2'd1;
            tb_en   <= 1'b1;
        end
    end

    // Behavioural single-port OCM: read data appears one cycle after the address.
    always @(posedge clk) begin
        bus.ocm_dataout <= ocm_mem[bus.ocm_addr];
        if (bus.ocm_we) ocm_mem[bus.ocm_addr] <= bus.ocm_datain;
    end

    always @(posedge clk) begin
        if (rst_n && bus.pix_valid && bus.pix_ready) begin
            if (bus.pix_x < 640 && bus.pix_y < 480)
                sb.push_back({19'(bus.pix_x + 640 * bus.pix_y), bus.pix_color});
            else if (oob_model < 255)
                oob_model++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check_eq("fifo_count", bus.fifo_count, sb.size());
            if (int'(bus.fifo_count) > max_cnt) max_cnt = int'(bus.fifo_count);
            check_eq("pix_ready", bus.pix_ready, tb_en && (sb.size() != 8));
            check_eq("oob_count", bus.oob_count, oob_model);
            case (tb_slot)
                2'd0: begin
                    exp_scan = (bus.draw_x < 640 && bus.draw_y < 480) ? bus.draw_x + 640 * bus.draw_y : 0;
                    check_eq("scan_addr", bus.ocm_addr, exp_scan);
                    check_eq("scan_we", bus.ocm_we, 0);
                end
                2'd2: begin
                    check_eq("idle_addr", bus.ocm_addr, 0);
                    check_eq("idle_we", bus.ocm_we, 0);
                end
                default: begin
                    check_eq("wr_we", bus.ocm_we, sb.size() != 0);
                    if (bus.ocm_we && sb.size() != 0) begin
                        exp_wr = sb.pop_front();
                        check_eq("wr_addr", bus.ocm_addr, exp_wr.addr);
                        check_eq("wr_data", bus.ocm_datain, exp_wr.data);
                    end
                end
            endcase
        end
    end

    task automatic push(input int x, input int y, input int c);
        int n;
        bus.pix_x     = 10'(x);
        bus.pix_y     = 10'(y);
        bus.pix_color = 4'(c);
        bus.pix_valid = 1'b1;
        n = 0;
        while (!bus.pix_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("push_wait", n < 50, 1);
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_wait", n < 100, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_vga(input int x, input int y, input int exp);
        int n;
        #1;
        bus.draw_x = 10'(x);
        bus.draw_y = 10'(y);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tb_slot != 2'd0 && n < 8);
        check_eq("vga_wait", n < 8, 1);
        repeat (2) @(negedge clk);
        check_eq("vga_pixel", bus.vga_pixel, exp);
        #1;
        bus.draw_x = 10'd700;
        bus.draw_y = 10'd700;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 307200; i++) ocm_mem[i] = 4'd0;
        bus.pix_x = '0;
        bus.pix_y = '0;
        bus.pix_color = '0;
        bus.pix_valid = 1'b0;
        bus.draw_x = 10'd700;
        bus.draw_y = 10'd700;

        repeat (3) @(negedge clk);
        check_eq("rst_ready", bus.pix_ready, 0);
        check_eq("rst_count", bus.fifo_count, 0);
        check_eq("rst_vga", bus.vga_pixel, 0);
        check_eq("rst_oob", bus.oob_count, 0);
        check_eq("rst_we", bus.ocm_we, 0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 check_eq("ready_after_rel", bus.pix_ready, 1);
        @(negedge clk);

        push(0, 0, 5);
        bus.pix_valid = 1'b0;
        drain();
        check_vga(0, 0, 5);

        @(negedge clk);
        push(639, 479, 9);
        push(640, 0, 3);
        push(0, 480, 4);
        bus.pix_valid = 1'b0;
        drain();
        check_eq("oob_two", bus.oob_count, 2);
        check_vga(639, 479, 9);

        @(negedge clk);
        max_cnt = 0;
        for (int i = 0; i < 24; i++) push(i, 1, i & 15);
        bus.pix_valid = 1'b0;
        drain();
        check_eq("fifo_peak", max_cnt, 8);
        check_vga(23, 1, 7);
        check_vga(10, 1, 10);

        @(negedge clk);
        push(5, 5, 1);
        push(5, 5, 2);
        bus.pix_valid = 1'b0;
        drain();
        check_vga(5, 5, 2);

        @(negedge clk);
        for (int i = 0; i < 6; i++) push(100 + i, 2, i + 1);
        bus.pix_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tb_slot != 2'd2 && n < 8);
        check_eq("slot2_wait", n < 8, 1);
        check_eq("burst_pending", sb.size() != 0, 1);
        #2 rst_n = 1'b0;
        sb.delete();
        oob_model = 0;
        #1;
        check_eq("midrst_count", bus.fifo_count, 0);
        check_eq("midrst_we", bus.ocm_we, 0);
        check_eq("midrst_ready", bus.pix_ready, 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        push(1, 2, 12);
        bus.pix_valid = 1'b0;
        drain();
        check_vga(1, 2, 12);

        @(negedge clk);
        for (int i = 0; i < 300; i++) push(640 + (i % 50), 0, 1);
        bus.pix_valid = 1'b0;
        @(negedge clk);
        check_eq("oob_sat", bus.oob_count, 255);
        check_eq("oob_fifo_empty", bus.fifo_count, 0);

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
